// File: rtl/core_sequencer_if.sv
// Instruction-memory port of the core sequencer: request handshake plus response.
interface core_sequencer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetches one instruction, holds it for Decode/Execute,
// owns the PC, gates register-file writes, counts retirements and halts on faults.
module core_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    core_sequencer_if.master         imem,
    output logic [31:0]              instr_word,
    input  logic                     decode_illegal,
    output logic [31:0]              pc,
    input  logic [31:0]              exec_new_pc,
    input  logic                     exec_reg_we,
    output logic                     rf_we,
    output logic                     retire,
    output logic [31:0]              retired_count,
    output logic                     fault,
    output logic [1:0]               fault_cause,
    output logic [2:0]               state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH_REQ  = 3'd1,
        S_FETCH_WAIT = 3'd2,
        S_DECODE     = 3'd3,
        S_EXECUTE    = 3'd4,
        S_WRITEBACK  = 3'd5,
        S_HALT       = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_ILLEGAL   = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'd3;
    // Counter starts at 0 on entry, so the last permitted wait cycle is FETCH_TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST       = 8'(FETCH_TIMEOUT - 1);

    state_t      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] instr_q,   instr_d;
    logic [7:0]  wait_q,    wait_d;
    logic [31:0] new_pc_q,  new_pc_d;
    logic        we_q,      we_d;
    logic [31:0] retired_count_q, retired_count_d;
    logic        fault_q,   fault_d;
    logic [1:0]  cause_q,   cause_d;
    logic        req_valid;
    logic        rf_we_c;
    logic        retire_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            pc_q            <= RESET_PC;
            instr_q         <= 32'd0;
            wait_q          <= 8'd0;
            new_pc_q        <= 32'd0;
            we_q            <= 1'b0;
            retired_count_q <= 32'd0;
            fault_q         <= 1'b0;
            cause_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            wait_q          <= wait_d;
            new_pc_q        <= new_pc_d;
            we_q            <= we_d;
            retired_count_q <= retired_count_d;
            fault_q         <= fault_d;
            cause_q         <= cause_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        wait_d          = wait_q;
        new_pc_d        = new_pc_q;
        we_d            = we_q;
        retired_count_d = retired_count_q;
        fault_d         = fault_q;
        cause_d         = cause_q;
        req_valid       = 1'b0;
        rf_we_c         = 1'b0;
        retire_c        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH_REQ;
            end
            S_FETCH_REQ: begin
                req_valid = 1'b1;
                if (imem.imem_req_ready) begin
                    state_d = S_FETCH_WAIT;
                    wait_d  = 8'd0;
                end
            end
            S_FETCH_WAIT: begin
                // A response landing on the timeout cycle still wins.
                if (imem.imem_resp_valid) begin
                    instr_d = imem.imem_resp_data;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (decode_illegal) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                new_pc_d = exec_new_pc;
                we_d     = exec_reg_we;
                if (exec_new_pc[1:0] != 2'b00) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                    cause_d = CAUSE_MISALIGN;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                rf_we_c         = we_q;
                retire_c        = 1'b1;
                pc_d            = new_pc_q;
                retired_count_d = retired_count_q + 32'd1;
                state_d         = run ? S_FETCH_REQ : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = pc_q;
    assign instr_word          = instr_q;
    assign pc                  = pc_q;
    assign rf_we               = rf_we_c;
    assign retire              = retire_c;
    assign retired_count       = retired_count_q;
    assign fault               = fault_q;
    assign fault_cause         = cause_q;
    assign state_dbg           = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer (FETCH_TIMEOUT = 4).
module tb_core_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] instr_word;
    logic        decode_illegal;
    logic [31:0] pc;
    logic [31:0] exec_new_pc;
    logic        exec_reg_we;
    logic        rf_we;
    logic        retire;
    logic [31:0] retired_count;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [2:0]  state_dbg;

    int n_total = 0;
    int n_pass  = 0;

    core_sequencer_if imem ();

    core_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .imem           (imem.master),
        .instr_word     (instr_word),
        .decode_illegal (decode_illegal),
        .pc             (pc),
        .exec_new_pc    (exec_new_pc),
        .exec_reg_we    (exec_reg_we),
        .rf_we          (rf_we),
        .retire         (retire),
        .retired_count  (retired_count),
        .fault          (fault),
        .fault_cause    (fault_cause),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Runs one instruction from IDLE: req_ready held low for 'stall' request cycles,
    // response raised once 'resp_delay' wait cycles have elapsed.
    task automatic do_instr(input int stall, input int resp_delay, input logic [31:0] word,
                            input logic ill, input logic [31:0] npc, input logic we,
                            input logic [31:0] exp_addr,
                            output int retire_cyc, output int halt_cyc,
                            output logic rf_seen, output logic wb_rf, output int req_errs);
        int k_req;
        int k_wait;
        k_req = 0; k_wait = 0;
        retire_cyc = 0; halt_cyc = 0; rf_seen = 1'b0; wb_rf = 1'b0; req_errs = 0;
        decode_illegal = ill;
        exec_new_pc    = npc;
        exec_reg_we    = we;
        imem.imem_resp_data  = word;
        imem.imem_resp_valid = 1'b0;
        imem.imem_req_ready  = (stall == 0);
        run = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (rf_we === 1'b1) rf_seen = 1'b1;
            if (state_dbg == 3'd1) begin
                k_req++;
                if (imem.imem_req_valid !== 1'b1 || imem.imem_addr !== exp_addr) req_errs++;
                imem.imem_req_ready = (k_req > stall);
            end
            if (state_dbg == 3'd2) begin
                imem.imem_resp_valid = (k_wait >= resp_delay);
                k_wait++;
            end else begin
                imem.imem_resp_valid = 1'b0;
            end
            if (retire === 1'b1) begin
                retire_cyc = cyc;
                wb_rf      = rf_we;
                run        = 1'b0;
            end
            if (state_dbg == 3'd6) begin
                halt_cyc = cyc;
                break;
            end
            if (state_dbg == 3'd0) break;
        end
        run = 1'b0;
        imem.imem_resp_valid = 1'b0;
        imem.imem_req_ready  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state_dbg), 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_instr"}, instr_word, 32'd0);
        chk({tag, "_count"}, retired_count, 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_cause"}, 32'(fault_cause), 32'd0);
        chk({tag, "_reqv"}, 32'(imem.imem_req_valid), 32'd0);
        chk({tag, "_rfwe"}, 32'(rf_we), 32'd0);
        chk({tag, "_retire"}, 32'(retire), 32'd0);
    endtask

    initial begin
        int   rc;
        int   hc;
        int   errs;
        logic rfs;
        logic wbr;

        reset = 1'b1; run = 1'b0; decode_illegal = 1'b0;
        exec_new_pc = 32'd0; exec_reg_we = 1'b0;
        imem.imem_req_ready = 1'b0; imem.imem_resp_valid = 1'b0; imem.imem_resp_data = 32'd0;
        tick(); tick();
        check_reset_vals("rst");
        reset = 1'b0;

        // Test 1: cycle-by-cycle addi x1,x0,5
        run = 1'b1; imem.imem_req_ready = 1'b1;
        exec_new_pc = 32'd4; exec_reg_we = 1'b1; imem.imem_resp_data = 32'h0050_0093;
        tick();
        chk("t1_c1_state", 32'(state_dbg), 32'd1);
        chk("t1_c1_reqv", 32'(imem.imem_req_valid), 32'd1);
        chk("t1_c1_addr", imem.imem_addr, 32'd0);
        tick();
        chk("t1_c2_state", 32'(state_dbg), 32'd2);
        chk("t1_c2_reqv", 32'(imem.imem_req_valid), 32'd0);
        imem.imem_resp_valid = 1'b1;
        tick();
        imem.imem_resp_valid = 1'b0;
        chk("t1_c3_state", 32'(state_dbg), 32'd3);
        chk("t1_c3_instr", instr_word, 32'h0050_0093);
        tick();
        chk("t1_c4_state", 32'(state_dbg), 32'd4);
        chk("t1_c4_rfwe", 32'(rf_we), 32'd0);
        run = 1'b0;
        tick();
        chk("t1_c5_state", 32'(state_dbg), 32'd5);
        chk("t1_c5_rfwe", 32'(rf_we), 32'd1);
        chk("t1_c5_retire", 32'(retire), 32'd1);
        chk("t1_c5_instr", instr_word, 32'h0050_0093);
        tick();
        chk("t1_pc", pc, 32'd4);
        chk("t1_count", retired_count, 32'd1);
        chk("t1_idle", 32'(state_dbg), 32'd0);
        chk("t1_rfwe_off", 32'(rf_we), 32'd0);

        // Test 2: three stall cycles delay retire by exactly three
        do_instr(3, 0, 32'h0000_0013, 1'b0, 32'd8, 1'b0, 32'd4, rc, hc, rfs, wbr, errs);
        chk("t2_retire_cyc", 32'(rc), 32'd8);
        chk("t2_req_hold", 32'(errs), 32'd0);
        chk("t2_rf_never", 32'(rfs), 32'd0);
        chk("t2_pc", pc, 32'd8);
        chk("t2_count", retired_count, 32'd2);

        // Test 6b: counter wrap
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        tick();
        chk("t6_preload", retired_count, 32'hFFFF_FFFF);
        do_instr(0, 0, 32'h0000_0013, 1'b0, 32'hC, 1'b1, 32'd8, rc, hc, rfs, wbr, errs);
        chk("t6_wrap", retired_count, 32'd0);
        chk("t6_retire_cyc", 32'(rc), 32'd5);
        chk("t6_wb_rf", 32'(wbr), 32'd1);
        chk("t6_pc", pc, 32'hC);

        // Test 5b: response on the timeout cycle wins
        do_instr(0, 3, 32'h1234_5678, 1'b0, 32'h10, 1'b1, 32'hC, rc, hc, rfs, wbr, errs);
        chk("t5b_retire_cyc", 32'(rc), 32'd8);
        chk("t5b_fault", 32'(fault), 32'd0);
        chk("t5b_pc", pc, 32'h10);
        chk("t5b_count", retired_count, 32'd1);

        // Test 4: misaligned next PC
        do_instr(0, 0, 32'h0000_0013, 1'b0, 32'h6, 1'b1, 32'h10, rc, hc, rfs, wbr, errs);
        chk("t4_state", 32'(state_dbg), 32'd6);
        chk("t4_fault", 32'(fault), 32'd1);
        chk("t4_cause", 32'(fault_cause), 32'd2);
        chk("t4_rf_never", 32'(rfs), 32'd0);
        chk("t4_no_retire", 32'(rc), 32'd0);
        chk("t4_pc", pc, 32'h10);
        chk("t4_count", retired_count, 32'd1);

        // Test 6a: reset with a nonzero counter, then reset during FETCH_WAIT
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("t6_rst_halt");
        run = 1'b1; imem.imem_req_ready = 1'b1;
        tick(); tick();
        chk("t6_in_wait", 32'(state_dbg), 32'd2);
        reset = 1'b1; run = 1'b0; imem.imem_req_ready = 1'b0;
        tick();
        reset = 1'b0;
        check_reset_vals("t6_rst_wait");
        tick();
        chk("t6_stays_idle", 32'(state_dbg), 32'd0);

        // Test 5a: no response -> timeout after 4 wait cycles
        do_instr(0, 99, 32'h0000_0013, 1'b0, 32'h4, 1'b1, 32'd0, rc, hc, rfs, wbr, errs);
        chk("t5_halt_cyc", 32'(hc), 32'd6);
        chk("t5_cause", 32'(fault_cause), 32'd3);
        chk("t5_fault", 32'(fault), 32'd1);
        chk("t5_pc", pc, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Test 3: illegal instruction on first fetch, then run toggles
        do_instr(0, 0, 32'hFFFF_FFFF, 1'b1, 32'h4, 1'b1, 32'd0, rc, hc, rfs, wbr, errs);
        chk("t3_state", 32'(state_dbg), 32'd6);
        chk("t3_fault", 32'(fault), 32'd1);
        chk("t3_cause", 32'(fault_cause), 32'd1);
        chk("t3_pc", pc, 32'd0);
        chk("t3_rf_never", 32'(rfs), 32'd0);
        decode_illegal = 1'b0;
        imem.imem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run = i[0];
            tick();
            if (rf_we === 1'b1) rfs = 1'b1;
        end
        chk("t3_sticky_state", 32'(state_dbg), 32'd6);
        chk("t3_sticky_cause", 32'(fault_cause), 32'd1);
        chk("t3_no_req", 32'(imem.imem_req_valid), 32'd0);
        chk("t3_rf_after", 32'(rfs), 32'd0);
        chk("t3_count", retired_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
